l2_host_req_arb: RTL and testbench

- Shares the single host request port between the per-stream L2 request generators (nstrms requesters) using round-robin arbitration.
- Enforces a global limit on outstanding host reads through a credit counter. Credits are returned by the host response handshake.
- Routes each host response back to its stream as a decoded valid.
- Sits between the per-stream L2 request logic and the host request/response interface, in the clk1x domain.

---
 rtl/l2_arb_pkg.sv | 16 +
 rtl/l2_host_req_arb_rr_pick.sv | 29 ++
 rtl/l2_host_req_arb.sv | 101 ++++++++++
 tb/tb_l2_host_req_arb.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/l2_arb_pkg.sv
// Shared constants and types for the L2 host request arbiter.
// host_req_t is sized for the default configuration; the arbiter re-declares it per instance.
package l2_arb_pkg;
    localparam int ADDR_WIDTH   = 64;
    localparam int NSTRMS       = 64;
    localparam int NSTRMS_WIDTH = $clog2(NSTRMS);

    function automatic int cnt_w(input int max_out);
        return $clog2(max_out + 1);
    endfunction

    typedef struct packed {
        logic [NSTRMS_WIDTH-1:0] sid;
        logic [ADDR_WIDTH-1:0]   ea;
    } host_req_t;
endpackage

// File: rtl/l2_host_req_arb_rr_pick.sv
// Combinational round-robin picker.
// The request vector is duplicated, and the lower copy is masked below the pointer, so that one priority scan handles the wrap.
module l2_rr_pick #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] i_req,
    input  logic [W-1:0] i_ptr,
    input  logic         i_en,
    output logic [N-1:0] o_gnt,
    output logic [W-1:0] o_id,
    output logic         o_any
);
    logic [2*N-1:0] w_dbl;
    logic [W:0]     w_sel;

    always_comb begin
        w_dbl = {i_req, i_req & ({N{1'b1}} << i_ptr)};
        w_sel = '0;
        // Scan from the top so that the lowest set bit wins.
        for (int i = 2*N-1; i >= 0; i--) begin
            if (w_dbl[i]) w_sel = (W+1)'(i);
        end
    end

    assign o_id  = W'((w_sel >= (W+1)'(N)) ? (w_sel - (W+1)'(N)) : w_sel);
    assign o_any = i_en & (|i_req);
    assign o_gnt = o_any ? (N'(1) << o_id) : '0;
endmodule

// File: rtl/l2_host_req_arb.sv
// Round-robin arbiter from the per-stream L2 request generators onto the single host request port.
// It applies a credit limit on outstanding reads and decodes host responses back to their streams.
module l2_host_req_arb
    import l2_arb_pkg::*;
#(
    parameter int addr_width   = ADDR_WIDTH,
    parameter int nstrms       = NSTRMS,
    parameter int nstrms_width = $clog2(nstrms),
    parameter int max_out      = 32,
    parameter int cnt_width    = cnt_w(max_out)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [nstrms-1:0]            i_req_v,
    output logic [nstrms-1:0]            i_req_r,
    input  logic [nstrms*addr_width-1:0] i_req_ea,
    output logic                         o_req_v,
    input  logic                         o_req_r,
    output logic [nstrms_width-1:0]      o_req_sid,
    output logic [addr_width-1:0]        o_req_ea,
    input  logic                         i_rsp_v,
    output logic                         i_rsp_r,
    input  logic [nstrms_width-1:0]      i_rsp_sid,
    output logic [nstrms-1:0]            o_rsp_v,
    input  logic [nstrms-1:0]            o_rsp_r,
    output logic [cnt_width-1:0]         o_inflight,
    output logic                         o_err
);
    typedef struct packed {
        logic [nstrms_width-1:0] sid;
        logic [addr_width-1:0]   ea;
    } req_t;

    logic                    r_req_v;
    req_t                    r_req;
    logic [nstrms_width-1:0] r_ptr;
    logic [cnt_width-1:0]    r_inflight;
    logic                    r_err;

    logic                    w_ld;
    logic                    w_en;
    logic [nstrms-1:0]       w_gnt;
    logic [nstrms_width-1:0] w_id;
    logic                    w_any;
    logic [addr_width-1:0]   w_ea;
    logic                    w_rsp_hs;

    assign w_ld = !r_req_v || o_req_r;
    // Credit is checked against the registered count only, so a same-cycle response never frees a slot early.
    assign w_en = !reset && w_ld && (r_inflight < cnt_width'(max_out));

    l2_rr_pick #(.N(nstrms), .W(nstrms_width)) u_pick (
        .i_req (i_req_v),
        .i_ptr (r_ptr),
        .i_en  (w_en),
        .o_gnt (w_gnt),
        .o_id  (w_id),
        .o_any (w_any)
    );

    assign i_req_r  = w_gnt;
    assign w_ea     = i_req_ea[w_id*addr_width +: addr_width];

    assign o_rsp_v  = (!reset && i_rsp_v) ? (nstrms'(1) << i_rsp_sid) : '0;
    assign i_rsp_r  = !reset && o_rsp_r[i_rsp_sid];
    assign w_rsp_hs = i_rsp_v && i_rsp_r;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_req_v    <= 1'b0;
            r_req      <= '0;
            r_ptr      <= '0;
            r_inflight <= '0;
            r_err      <= 1'b0;
        end else begin
            if (w_ld) begin
                r_req_v <= w_any;
                if (w_any) begin
                    r_req.sid <= w_id;
                    r_req.ea  <= w_ea;
                    r_ptr     <= (w_id == nstrms_width'(nstrms-1)) ? '0 : w_id + 1'b1;
                end
            end
            // A response with nothing in flight is flagged and not counted; a concurrent grant still counts.
            if (w_rsp_hs && r_inflight == '0) begin
                r_err <= 1'b1;
                if (w_any) r_inflight <= r_inflight + 1'b1;
            end else if (w_any && !w_rsp_hs) begin
                r_inflight <= r_inflight + 1'b1;
            end else if (!w_any && w_rsp_hs) begin
                r_inflight <= r_inflight - 1'b1;
            end
        end
    end

    assign o_req_v    = r_req_v;
    assign o_req_sid  = r_req.sid;
    assign o_req_ea   = r_req.ea;
    assign o_inflight = r_inflight;
    assign o_err      = r_err;
endmodule

// File: tb/tb_l2_host_req_arb.sv
// Directed and randomized checks of l2_host_req_arb against a cycle-level reference model.
module tb_l2_host_req_arb;
    localparam int NS = 4;
    localparam int AW = 32;
    localparam int SW = 2;
    localparam int MO = 6;
    localparam int CW = 3;

    logic              clk = 1'b0;
    logic              reset;
    logic [NS-1:0]     req_v;
    logic [NS-1:0]     req_r;
    logic [NS*AW-1:0]  req_ea;
    logic              hreq_v;
    logic              hreq_r;
    logic [SW-1:0]     hreq_sid;
    logic [AW-1:0]     hreq_ea;
    logic              rsp_v;
    logic              rsp_r;
    logic [SW-1:0]     rsp_sid;
    logic [NS-1:0]     srsp_v;
    logic [NS-1:0]     srsp_r;
    logic [CW-1:0]     inflight;
    logic              err;

    int tests = 0;
    int fails = 0;

    // Reference model state.
    int       m_ptr, m_inf, m_sid;
    bit       m_v, m_err;
    bit [AW-1:0] m_ea;

    always #5 clk = ~clk;

    l2_host_req_arb #(.addr_width(AW), .nstrms(NS), .nstrms_width(SW), .max_out(MO), .cnt_width(CW)) dut (
        .clk(clk), .reset(reset),
        .i_req_v(req_v), .i_req_r(req_r), .i_req_ea(req_ea),
        .o_req_v(hreq_v), .o_req_r(hreq_r), .o_req_sid(hreq_sid), .o_req_ea(hreq_ea),
        .i_rsp_v(rsp_v), .i_rsp_r(rsp_r), .i_rsp_sid(rsp_sid),
        .o_rsp_v(srsp_v), .o_rsp_r(srsp_r),
        .o_inflight(inflight), .o_err(err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: check combinational outputs, advance the model on the edge, check registered outputs.
    task automatic step();
        int g;
        bit ld, hs;
        logic [NS-1:0] exp_gnt;
        #1;
        ld = !m_v || hreq_r;
        g  = -1;
        if (!reset && ld && m_inf < MO) begin
            for (int j = 0; j < NS; j++) begin
                int k;
                k = (m_ptr + j) % NS;
                if (g < 0 && req_v[k]) g = k;
            end
        end
        exp_gnt = (g >= 0) ? NS'(1 << g) : '0;
        hs = !reset && rsp_v && srsp_r[rsp_sid];
        chk("i_req_r", 64'(req_r), 64'(exp_gnt));
        chk("o_rsp_v", 64'(srsp_v), (!reset && rsp_v) ? 64'(1 << rsp_sid) : 64'd0);
        chk("i_rsp_r", 64'(rsp_r), 64'(!reset && srsp_r[rsp_sid]));
        @(posedge clk);
        if (reset) begin
            m_ptr = 0; m_inf = 0; m_v = 0; m_sid = 0; m_ea = '0; m_err = 0;
        end else begin
            if (ld) begin
                m_v = (g >= 0);
                if (g >= 0) begin
                    m_sid = g;
                    m_ea  = req_ea[g*AW +: AW];
                    m_ptr = (g + 1) % NS;
                end
            end
            if (hs && m_inf == 0) begin
                m_err = 1;
                m_inf = m_inf + ((g >= 0) ? 1 : 0);
            end else begin
                m_inf = m_inf + ((g >= 0) ? 1 : 0) - (hs ? 1 : 0);
            end
        end
        #1;
        chk("o_req_v", 64'(hreq_v), 64'(m_v));
        chk("o_req_sid", 64'(hreq_sid), 64'(m_sid));
        chk("o_req_ea", 64'(hreq_ea), 64'(m_ea));
        chk("o_inflight", 64'(inflight), 64'(m_inf));
        chk("o_err", 64'(err), 64'(m_err));
    endtask

    task automatic drain();
        req_v = '0; rsp_v = 1'b1; srsp_r = '1;
        for (int n = 0; n < MO + 4 && m_inf > 0; n++) begin
            rsp_sid = SW'($urandom_range(0, NS-1));
            step();
        end
        rsp_v = 1'b0;
        chk("drain_empty", 64'(inflight), 64'd0);
    endtask

    initial begin
        reset = 1'b1; req_v = '1; req_ea = '0; hreq_r = 1'b1;
        rsp_v = 1'b1; rsp_sid = 2'd1; srsp_r = '1;
        m_ptr = 0; m_inf = 0; m_v = 0; m_sid = 0; m_ea = '0; m_err = 0;
        step(); step();
        reset = 1'b0; rsp_v = 1'b0;

        // Single requester, 1-cycle latency.
        req_v = 4'b0100; req_ea[2*AW +: AW] = 32'h1000;
        step();
        chk("single_sid", 64'(hreq_sid), 64'd2);
        chk("single_ea", 64'(hreq_ea), 64'h1000);

        // All valid: rotation continues from stream 3 until credits run out.
        req_v = '1;
        for (int i = 0; i < NS; i++) req_ea[i*AW +: AW] = 32'h100 * (i + 1);
        for (int i = 0; i < 6; i++) step();
        chk("credit_full", 64'(inflight), 64'(MO));
        // Response frees credit only for the following cycle.
        rsp_v = 1'b1; rsp_sid = 2'd1;
        step();
        rsp_v = 1'b0;
        step();
        chk("resume_sid", 64'(hreq_sid), 64'd0);
        drain();

        // Stall with stream 3 held.
        req_v = 4'b1000; req_ea[3*AW +: AW] = 32'hABC0;
        while (m_ptr != 3) begin req_v = 4'b0001 << m_ptr; step(); end
        req_v = 4'b1000; step();
        hreq_r = 1'b0; req_v = '1;
        for (int i = 0; i < 5; i++) step();
        chk("stall_sid", 64'(hreq_sid), 64'd3);
        chk("stall_ea", 64'(hreq_ea), 64'hABC0);
        hreq_r = 1'b1;
        step();
        chk("release_sid", 64'(hreq_sid), 64'd0);
        drain();

        // Grant and response in the same cycle leave the count unchanged.
        req_v = '1; step(); step();
        chk("inf_two", 64'(inflight), 64'd2);
        rsp_v = 1'b1; rsp_sid = 2'd0;
        step();
        chk("gr_rsp_same", 64'(inflight), 64'd2);
        drain();
        // Underflow sets the sticky error.
        rsp_v = 1'b1; rsp_sid = 2'd2;
        step();
        rsp_v = 1'b0;
        step();
        chk("err_sticky", 64'(err), 64'd1);

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            req_v   = NS'($urandom);
            req_ea  = {$urandom, $urandom, $urandom, $urandom};
            hreq_r  = ($urandom_range(0, 3) != 0);
            rsp_v   = $urandom_range(0, 1) == 1;
            rsp_sid = SW'($urandom);
            srsp_r  = NS'($urandom);
            reset   = ($urandom_range(0, 99) == 0);
            step();
        end
        reset = 1'b0; rsp_v = 1'b0;

        // Reset mid-stall with credits exhausted.
        drain();
        req_v = '1; hreq_r = 1'b1;
        for (int i = 0; i < MO; i++) step();
        hreq_r = 1'b0; step();
        reset = 1'b1; step();
        chk("rst_inf", 64'(inflight), 64'd0);
        chk("rst_v", 64'(hreq_v), 64'd0);
        reset = 1'b0; hreq_r = 1'b1;
        step();
        chk("post_rst_sid", 64'(hreq_sid), 64'd0);
        chk("post_rst_v", 64'(hreq_v), 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
